riscv_memory: RTL and testbench

- Unified instruction/data memory for the `riscv32` core.
- Sits directly downstream of the core's instruction-fetch and data-access buses and serves both ports from one word-addressed array.
- Each port has an independent request FSM with a valid/ack/ready handshake and a configurable fixed latency.
- The data port supports byte-enabled writes.

---
 rtl/riscv_memory.sv | 174 +++++++++++++++++
 tb/tb_riscv_memory.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_memory.sv
// Unified instruction/data memory for the riscv32 core: one word-addressed array
// served by two independent fixed-latency request ports (fetch and load/store).
module riscv_memory #(
    parameter logic [31:0] BASE_ADDR   = 32'h00010000,
    parameter int          DEPTH_WORDS = 16384,
    parameter int          LATENCY     = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instruction_valid,
    input  logic [31:0] instruction_addr,
    output logic [31:0] instruction_read,
    output logic        instruction_ready,
    output logic        instruction_ack,
    input  logic        data_read_valid,
    input  logic        data_write_valid,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_write,
    input  logic [3:0]  data_write_byte,
    output logic [31:0] data_read,
    output logic        data_ready,
    output logic        data_ack
);

    localparam int         AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    localparam logic       SINGLE = (LATENCY == 1);

    typedef enum logic {IDLE, BUSY} state_e;

    logic [31:0] mem [DEPTH_WORDS];

    state_e      i_state_q, i_state_d;
    logic [3:0]  i_cnt_q, i_cnt_d;
    logic [31:0] i_addr_q, i_addr_d;
    logic        i_ack_q, i_ack_d;
    logic        i_ready_q, i_ready_d;
    logic [31:0] i_read_q, i_read_d;
    logic        i_accept;
    logic [31:0] i_idx;
    logic [31:0] i_word;

    state_e      d_state_q, d_state_d;
    logic [3:0]  d_cnt_q, d_cnt_d;
    logic [31:0] d_addr_q, d_addr_d;
    logic [31:0] d_wdata_q, d_wdata_d;
    logic [3:0]  d_be_q, d_be_d;
    logic        d_wr_q, d_wr_d;
    logic        d_ack_q, d_ack_d;
    logic        d_ready_q, d_ready_d;
    logic [31:0] d_read_q, d_read_d;
    logic        d_accept;
    logic [31:0] d_idx;
    logic        d_in_range;
    logic [31:0] d_word;
    logic        d_wen;

    // Ready is registered, so it is raised on the edge where the counter moves 1 -> 0
    // (or on acceptance itself when the latency is a single cycle).
    always_comb begin
        i_accept  = instruction_valid && ((i_state_q == IDLE) || i_ready_q);
        i_state_d = i_state_q;
        i_cnt_d   = i_cnt_q;
        i_addr_d  = i_addr_q;
        i_ack_d   = i_accept;
        i_ready_d = 1'b0;
        if (i_accept) begin
            i_state_d = BUSY;
            i_cnt_d   = LAT_M1;
            i_addr_d  = instruction_addr;
            i_ready_d = SINGLE;
        end else if (i_state_q == BUSY) begin
            if (i_cnt_q == 4'd0) begin
                i_state_d = IDLE;
            end else begin
                i_cnt_d   = i_cnt_q - 4'd1;
                i_ready_d = (i_cnt_q == 4'd1);
            end
        end
        i_idx    = (i_addr_d - BASE_ADDR) >> 2;
        i_word   = (i_idx < 32'(DEPTH_WORDS)) ? mem[i_idx[AW-1:0]] : 32'h0;
        i_read_d = i_ready_d ? i_word : i_read_q;
    end

    always_comb begin
        d_accept  = (data_read_valid || data_write_valid) &&
                    ((d_state_q == IDLE) || d_ready_q);
        d_state_d = d_state_q;
        d_cnt_d   = d_cnt_q;
        d_addr_d  = d_addr_q;
        d_wdata_d = d_wdata_q;
        d_be_d    = d_be_q;
        d_wr_d    = d_wr_q;
        d_ack_d   = d_accept;
        d_ready_d = 1'b0;
        if (d_accept) begin
            d_state_d = BUSY;
            d_cnt_d   = LAT_M1;
            d_addr_d  = data_addr;
            d_wdata_d = data_write;
            d_be_d    = data_write_byte;
            d_wr_d    = data_write_valid;
            d_ready_d = SINGLE;
        end else if (d_state_q == BUSY) begin
            if (d_cnt_q == 4'd0) begin
                d_state_d = IDLE;
            end else begin
                d_cnt_d   = d_cnt_q - 4'd1;
                d_ready_d = (d_cnt_q == 4'd1);
            end
        end
        d_idx      = (d_addr_d - BASE_ADDR) >> 2;
        d_in_range = (d_idx < 32'(DEPTH_WORDS));
        d_word     = d_in_range ? mem[d_idx[AW-1:0]] : 32'h0;
        d_read_d   = (d_ready_d && !d_wr_d) ? d_word : d_read_q;
        d_wen      = reset && d_ready_d && d_wr_d && d_in_range;
    end

    // Array is never reset; a fetch sampling on the commit edge sees pre-write data.
    always_ff @(posedge clk) begin
        if (d_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (d_be_d[b]) begin
                    mem[d_idx[AW-1:0]][8*b +: 8] <= d_wdata_d[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_state_q <= IDLE;
            i_cnt_q   <= 4'd0;
            i_addr_q  <= 32'h0;
            i_ack_q   <= 1'b0;
            i_ready_q <= 1'b0;
            i_read_q  <= 32'h0;
            d_state_q <= IDLE;
            d_cnt_q   <= 4'd0;
            d_addr_q  <= 32'h0;
            d_wdata_q <= 32'h0;
            d_be_q    <= 4'h0;
            d_wr_q    <= 1'b0;
            d_ack_q   <= 1'b0;
            d_ready_q <= 1'b0;
            d_read_q  <= 32'h0;
        end else begin
            i_state_q <= i_state_d;
            i_cnt_q   <= i_cnt_d;
            i_addr_q  <= i_addr_d;
            i_ack_q   <= i_ack_d;
            i_ready_q <= i_ready_d;
            i_read_q  <= i_read_d;
            d_state_q <= d_state_d;
            d_cnt_q   <= d_cnt_d;
            d_addr_q  <= d_addr_d;
            d_wdata_q <= d_wdata_d;
            d_be_q    <= d_be_d;
            d_wr_q    <= d_wr_d;
            d_ack_q   <= d_ack_d;
            d_ready_q <= d_ready_d;
            d_read_q  <= d_read_d;
        end
    end

    assign instruction_read  = i_read_q;
    assign instruction_ready = i_ready_q;
    assign instruction_ack   = i_ack_q;
    assign data_read         = d_read_q;
    assign data_ready        = d_ready_q;
    assign data_ack          = d_ack_q;

endmodule

// File: tb/tb_riscv_memory.sv
// Testbench for riscv_memory: two instances (latency 2 and latency 1) checked
// against a word-array reference model with directed and randomized requests.
module tb_riscv_memory;

    localparam int          DEPTH = 16384;
    localparam logic [31:0] BASE  = 32'h00010000;

    logic        clk = 1'b0;
    logic        reset;
    logic        iv   [2];
    logic [31:0] ia   [2];
    logic [31:0] ird  [2];
    logic        irdy [2];
    logic        iack [2];
    logic        drv  [2];
    logic        dwv  [2];
    logic [31:0] da   [2];
    logic [31:0] dw   [2];
    logic [3:0]  dbe  [2];
    logic [31:0] drd  [2];
    logic        drdy [2];
    logic        dack [2];

    logic [31:0] mdl     [2][DEPTH];
    logic [31:0] last_dr [2];
    int          compared   = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    riscv_memory #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset),
        .instruction_valid(iv[0]), .instruction_addr(ia[0]), .instruction_read(ird[0]),
        .instruction_ready(irdy[0]), .instruction_ack(iack[0]),
        .data_read_valid(drv[0]), .data_write_valid(dwv[0]), .data_addr(da[0]),
        .data_write(dw[0]), .data_write_byte(dbe[0]), .data_read(drd[0]),
        .data_ready(drdy[0]), .data_ack(dack[0])
    );

    riscv_memory #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1), .INIT_FILE("")) dut1 (
        .clk(clk), .reset(reset),
        .instruction_valid(iv[1]), .instruction_addr(ia[1]), .instruction_read(ird[1]),
        .instruction_ready(irdy[1]), .instruction_ack(iack[1]),
        .data_read_valid(drv[1]), .data_write_valid(dwv[1]), .data_addr(da[1]),
        .data_write(dw[1]), .data_write_byte(dbe[1]), .data_read(drd[1]),
        .data_ready(drdy[1]), .data_ack(dack[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input int s, input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - BASE) >> 2;
        return (idx < DEPTH) ? mdl[s][idx] : 32'h0;
    endfunction

    task automatic mwrite(input int s, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] idx;
        idx = (a - BASE) >> 2;
        if (idx < DEPTH) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mdl[s][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'($urandom_range(0, BASE - 1));
        if (r == 1) return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 1000));
        return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
    endfunction

    task automatic check_reset_outputs(input int s);
        check("rst_i_read", ird[s], 32'h0);
        check("rst_i_ready", 32'(irdy[s]), 32'h0);
        check("rst_i_ack", 32'(iack[s]), 32'h0);
        check("rst_d_read", drd[s], 32'h0);
        check("rst_d_ready", 32'(drdy[s]), 32'h0);
        check("rst_d_ack", 32'(dack[s]), 32'h0);
    endtask

    // Fetch with ack expected one cycle after acceptance and ready LATENCY cycles after.
    task automatic applyStimulus_fetch(input int s, input logic [31:0] addr, input logic [31:0] exp);
        int lat;
        lat = (s == 0) ? 2 : 1;
        @(negedge clk);
        iv[s] = 1'b1;
        ia[s] = addr;
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                iv[s] = 1'b0;
                ia[s] = $urandom;
            end
            check("i_ack", 32'(iack[s]), 32'(k == 1));
            check("i_ready", 32'(irdy[s]), 32'(k == lat));
        end
        check("i_read", ird[s], exp);
    endtask

    task automatic applyStimulus_data(input int s, input logic rd, input logic wr, input logic [31:0] addr,
                                      input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
        int lat;
        lat = (s == 0) ? 2 : 1;
        @(negedge clk);
        drv[s] = rd;
        dwv[s] = wr;
        da[s]  = addr;
        dw[s]  = wd;
        dbe[s] = be;
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                drv[s] = 1'b0;
                dwv[s] = 1'b0;
                da[s]  = $urandom;
                dw[s]  = $urandom;
                dbe[s] = 4'($urandom);
            end
            check("d_ack", 32'(dack[s]), 32'(k == 1));
            check("d_ready", 32'(drdy[s]), 32'(k == lat));
        end
        check("d_read", drd[s], exp);
    endtask

    task automatic store(input int s, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        applyStimulus_data(s, 1'b0, 1'b1, addr, wd, be, last_dr[s]);
        mwrite(s, addr, wd, be);
    endtask

    task automatic load(input int s, input logic [31:0] addr);
        logic [31:0] exp;
        exp = mread(s, addr);
        applyStimulus_data(s, 1'b1, 1'b0, addr, $urandom, 4'($urandom), exp);
        last_dr[s] = exp;
    endtask

    task automatic fetch(input int s, input logic [31:0] addr);
        applyStimulus_fetch(s, addr, mread(s, addr));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] old;
        logic [31:0] wd;
        logic [3:0]  be;
        int unsigned s;

        reset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            iv[p] = 1'b0; ia[p] = '0; drv[p] = 1'b0; dwv[p] = 1'b0;
            da[p] = '0; dw[p] = '0; dbe[p] = '0; last_dr[p] = '0;
        end
        repeat (2) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        reset = 1'b1;

        for (int w = 0; w < 16; w++) begin
            store(0, BASE + 32'(4 * w), $urandom, 4'hF);
            store(1, BASE + 32'(4 * w), $urandom, 4'hF);
        end

        store(0, BASE, 32'hDEADBEEF, 4'hF);
        applyStimulus_fetch(0, 32'h00010000, 32'hDEADBEEF);

        store(0, 32'h00010004, 32'h11223344, 4'hF);
        store(0, 32'h00010004, 32'hAABBCCDD, 4'b0101);
        applyStimulus_data(0, 1'b1, 1'b0, 32'h00010004, 32'h0, 4'h0, 32'h11BB33DD);
        last_dr[0] = 32'h11BB33DD;

        // Latency 1, valid held for four cycles at sequential addresses.
        @(negedge clk);
        iv[1] = 1'b1;
        ia[1] = BASE;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("burst_ack", 32'(iack[1]), 32'h1);
            check("burst_ready", 32'(irdy[1]), 32'h1);
            check("burst_read", ird[1], mdl[1][j]);
            if (j < 3) ia[1] = BASE + 32'(4 * (j + 1));
            else iv[1] = 1'b0;
        end
        @(negedge clk);
        check("burst_end_ready", 32'(irdy[1]), 32'h0);
        check("burst_end_ack", 32'(iack[1]), 32'h0);

        load(0, 32'h00000000);
        check("below_base_read", drd[0], 32'h0);
        store(0, BASE + 32'(4 * DEPTH), 32'hCAFEF00D, 4'hF);
        load(0, BASE);
        check("word0_unchanged", drd[0], 32'hDEADBEEF);

        // Fetch and store to the same word completing in the same cycle.
        a   = BASE + 32'h0C;
        old = mread(0, a);
        fork
            applyStimulus_fetch(0, a, old);
            store(0, a, 32'h5A5AA5A5, 4'hF);
        join
        applyStimulus_fetch(0, a, 32'h5A5AA5A5);

        for (int n = 0; n < 60; n++) begin
            s  = $urandom_range(0, 1);
            a  = rand_addr();
            wd = $urandom;
            be = 4'($urandom);
            case ($urandom_range(0, 3))
                0: fetch(int'(s), a);
                1: load(int'(s), a);
                2: store(int'(s), a, wd, be);
                default: begin
                    applyStimulus_data(int'(s), 1'b1, 1'b1, a, wd, be, last_dr[s]);
                    mwrite(int'(s), a, wd, be);
                end
            endcase
        end

        // Reset pulsed while a store is in flight.
        a = BASE + 32'h14;
        store(0, a, 32'h0BADC0DE, 4'hF);
        @(negedge clk);
        dwv[0] = 1'b1;
        da[0]  = a;
        dw[0]  = 32'hFFFFFFFF;
        dbe[0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("abort_ack", 32'(dack[0]), 32'h1);
        dwv[0] = 1'b0;
        reset  = 1'b0;
        #1;
        check_reset_outputs(0);
        last_dr[0] = 32'h0;
        last_dr[1] = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_ready", 32'(drdy[0]), 32'h0);
        end
        load(0, a);
        check("abort_word_kept", drd[0], 32'h0BADC0DE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
